target_engine: RTL

TARGET_ENGINE -- requirements
Module: target_engine

---
 rtl/target_pkg.sv | 44 ++++
 rtl/target_unit.sv | 146 ++++++++++++++
 rtl/target_engine.sv | 102 ++++++++++
 3 files changed

// File: rtl/target_pkg.sv
// rtl/target_pkg.sv - target state/direction types, default play-field bounds and LFSR seed
package target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLY    = 2'd1,
    ST_FALL   = 2'd2,
    ST_ESCAPE = 2'd3
  } tgt_state_t;

  // Compass order; the first four double as the spawn directions (screen Y grows downward).
  typedef enum logic [2:0] {
    DIR_UL, DIR_U, DIR_UR, DIR_R, DIR_DR, DIR_D, DIR_DL, DIR_L
  } dir_t;

  localparam int DEF_X_MIN         = 3;
  localparam int DEF_X_MAX         = 639;
  localparam int DEF_Y_MIN         = 3;
  localparam int DEF_Y_MAX         = 399;
  localparam int DEF_BASE_STEP     = 3;
  localparam int DEF_MAX_STEP      = 15;
  localparam int DEF_ESCAPE_FRAMES = 255;
  localparam int DEF_REDIR_FRAMES  = 32;
  localparam int SPAWN_X0          = 64;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Unit-vector signs: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
  function automatic logic [1:0] dir_sx(input dir_t d);
    case (d)
      DIR_UR, DIR_R, DIR_DR: return 2'b01;
      DIR_UL, DIR_DL, DIR_L: return 2'b11;
      default:               return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dir_sy(input dir_t d);
    case (d)
      DIR_UL, DIR_U, DIR_UR: return 2'b11;
      DIR_DR, DIR_D, DIR_DL: return 2'b01;
      default:               return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/target_unit.sv
// rtl/target_unit.sv - one target: position, motion, life/redirect timers and state machine
module target_unit
  import target_pkg::*;
#(
  parameter int POS_W         = 10,
  parameter int TGT_SIZE      = 64,
  parameter int X_MIN         = DEF_X_MIN,
  parameter int X_MAX         = DEF_X_MAX,
  parameter int Y_MIN         = DEF_Y_MIN,
  parameter int Y_MAX         = DEF_Y_MAX,
  parameter int ESCAPE_FRAMES = DEF_ESCAPE_FRAMES,
  parameter int REDIR_FRAMES  = DEF_REDIR_FRAMES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             load,
  input  logic             kill,
  input  logic [POS_W-1:0] speed,
  input  logic [POS_W-1:0] load_x,
  input  dir_t             load_dir,
  input  dir_t             redir_dir,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output tgt_state_t       state,
  output logic             escaped,
  output logic             fallen
);

  localparam int MW     = POS_W + 1;
  localparam int WW     = POS_W + 2;
  localparam int LIFE_W = $clog2(ESCAPE_FRAMES + 1);
  localparam int RED_W  = $clog2(REDIR_FRAMES + 1);

  logic signed [MW-1:0] mx, my, spd_s;
  logic [LIFE_W-1:0]    life, life_n;
  logic [RED_W-1:0]     redir, redir_n;
  logic signed [WW-1:0] sum_x, sum_y;
  logic [POS_W-1:0]     nx, ny;
  logic [WW-1:0]        fall_y;
  logic                 hit_x_hi, hit_x_lo, hit_y_hi, hit_y_lo, hit_any;

  function automatic logic signed [MW-1:0] scale(input logic [1:0] sgn, input logic signed [MW-1:0] s);
    case (sgn)
      2'b01:   return s;
      2'b11:   return -s;
      default: return '0;
    endcase
  endfunction

  assign spd_s = $signed({1'b0, speed});

  // Next position saturates at 0 so a fast leftward/upward step never wraps.
  always_comb begin
    sum_x    = $signed({2'b00, x}) + $signed({mx[MW-1], mx});
    sum_y    = $signed({2'b00, y}) + $signed({my[MW-1], my});
    nx       = sum_x[WW-1] ? '0 : sum_x[POS_W-1:0];
    ny       = sum_y[WW-1] ? '0 : sum_y[POS_W-1:0];
    hit_x_hi = (int'(nx) + TGT_SIZE >= X_MAX);
    hit_x_lo = (int'(nx) <= X_MIN);
    hit_y_hi = (int'(ny) + TGT_SIZE >= Y_MAX);
    hit_y_lo = (int'(ny) <= Y_MIN);
    hit_any  = hit_x_hi | hit_x_lo | hit_y_hi | hit_y_lo;
    fall_y   = {2'b00, y} + {2'b00, speed};
    life_n   = life + LIFE_W'(1);
    redir_n  = redir + RED_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      x       <= '0;
      y       <= '0;
      mx      <= '0;
      my      <= '0;
      life    <= '0;
      redir   <= '0;
      escaped <= 1'b0;
      fallen  <= 1'b0;
    end else begin
      escaped <= 1'b0;
      fallen  <= 1'b0;
      case (state)
        ST_IDLE: if (load) begin
          state <= ST_FLY;
          x     <= load_x;
          y     <= POS_W'(Y_MAX - TGT_SIZE - 1);
          mx    <= scale(dir_sx(load_dir), spd_s);
          my    <= scale(dir_sy(load_dir), spd_s);
          life  <= '0;
          redir <= '0;
        end
        ST_FLY: if (kill) begin
          state <= ST_FALL;
          mx    <= '0;
          my    <= spd_s;
        end else if (frame_tick) begin
          x    <= nx;
          y    <= ny;
          life <= life_n;
          if (hit_x_hi)      mx <= -spd_s;
          else if (hit_x_lo) mx <= spd_s;
          if (hit_y_hi)      my <= -spd_s;
          else if (hit_y_lo) my <= spd_s;
          // The redirect interval restarts even when a wall bounce pre-empts it.
          if (int'(redir_n) >= REDIR_FRAMES) begin
            redir <= '0;
            if (!hit_any) begin
              mx <= scale(dir_sx(redir_dir), spd_s);
              my <= scale(dir_sy(redir_dir), spd_s);
            end
          end else begin
            redir <= redir_n;
          end
          if (int'(life_n) >= ESCAPE_FRAMES) begin
            state <= ST_ESCAPE;
            mx    <= '0;
            my    <= -spd_s;
          end
        end
        ST_FALL: if (frame_tick) begin
          if (int'(fall_y) + TGT_SIZE >= Y_MAX) begin
            y      <= POS_W'(Y_MAX - TGT_SIZE);
            state  <= ST_IDLE;
            fallen <= 1'b1;
            my     <= '0;
          end else begin
            y <= fall_y[POS_W-1:0];
          end
        end
        ST_ESCAPE: if (frame_tick) begin
          if (y < speed) begin
            y       <= '0;
            state   <= ST_IDLE;
            escaped <= 1'b1;
            my      <= '0;
          end else begin
            y <= y - speed;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/target_engine.sv
// rtl/target_engine.sv - shared LFSR, speed and spawn arbiter around NUM_TARGETS target units
module target_engine
  import target_pkg::*;
#(
  parameter int NUM_TARGETS   = 2,
  parameter int POS_W         = 10,
  parameter int TGT_SIZE      = 64,
  parameter int X_MIN         = DEF_X_MIN,
  parameter int X_MAX         = DEF_X_MAX,
  parameter int Y_MIN         = DEF_Y_MIN,
  parameter int Y_MAX         = DEF_Y_MAX,
  parameter int BASE_STEP     = DEF_BASE_STEP,
  parameter int MAX_STEP      = DEF_MAX_STEP,
  parameter int ESCAPE_FRAMES = DEF_ESCAPE_FRAMES,
  parameter int REDIR_FRAMES  = DEF_REDIR_FRAMES
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_tick,
  input  logic                         spawn,
  input  logic [NUM_TARGETS-1:0]       kill,
  input  logic [7:0]                   level,
  output logic [NUM_TARGETS*POS_W-1:0] TargetX,
  output logic [NUM_TARGETS*POS_W-1:0] TargetY,
  output logic [POS_W-1:0]             TargetS,
  output logic [NUM_TARGETS*2-1:0]     tgt_state,
  output logic [NUM_TARGETS-1:0]       escaped,
  output logic [NUM_TARGETS-1:0]       fallen,
  output logic                         spawn_drop
);

  logic [15:0]            lfsr;
  logic [NUM_TARGETS-1:0] idle, grant;
  logic [8:0]             raw_speed;
  logic [POS_W-1:0]       speed, load_x;
  dir_t                   load_dir, redir_dir;
  tgt_state_t             st [NUM_TARGETS];

  assign TargetS   = POS_W'(TGT_SIZE);
  assign load_x    = POS_W'(SPAWN_X0 + int'(lfsr[8:0]));
  assign load_dir  = dir_t'({1'b0, lfsr[1:0]});
  assign redir_dir = dir_t'(lfsr[2:0]);

  always_comb begin
    raw_speed = 9'(BASE_STEP) + {1'b0, level};
    speed     = (int'(raw_speed) > MAX_STEP) ? POS_W'(MAX_STEP) : POS_W'(raw_speed);
  end

  // Lowest-index IDLE target wins the spawn.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (spawn && idle[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr       <= LFSR_SEED;
      spawn_drop <= 1'b0;
    end else begin
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      spawn_drop <= spawn && (idle == '0);
    end
  end

  for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_unit
    target_unit #(
      .POS_W        (POS_W),
      .TGT_SIZE     (TGT_SIZE),
      .X_MIN        (X_MIN),
      .X_MAX        (X_MAX),
      .Y_MIN        (Y_MIN),
      .Y_MAX        (Y_MAX),
      .ESCAPE_FRAMES(ESCAPE_FRAMES),
      .REDIR_FRAMES (REDIR_FRAMES)
    ) u_unit (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .frame_tick(frame_tick),
      .load      (grant[i]),
      .kill      (kill[i]),
      .speed     (speed),
      .load_x    (load_x),
      .load_dir  (load_dir),
      .redir_dir (redir_dir),
      .x         (TargetX[i*POS_W +: POS_W]),
      .y         (TargetY[i*POS_W +: POS_W]),
      .state     (st[i]),
      .escaped   (escaped[i]),
      .fallen    (fallen[i])
    );
    assign tgt_state[2*i +: 2] = st[i];
    assign idle[i]             = (st[i] == ST_IDLE);
  end

endmodule
